// File: rtl/mii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : mii_tx_framer
//  Description : MII transmit framer. Takes payload bytes on a valid/ready
//                stream and drives preamble, SFD, payload, zero padding,
//                CRC-32 FCS and the inter-packet gap onto the MII nibble bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module mii_tx_framer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME      = 60,
  parameter int IFG_BYTES      = 12
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       eth_tx_en,
  output logic [3:0] eth_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_DATA = 3'd3,
    S_PAD  = 3'd4,
    S_FCS  = 3'd5,
    S_IFG  = 3'd6
  } state_t;

  localparam logic [15:0] c_pre_last  = 16'(2 * PREAMBLE_BYTES - 1);
  localparam logic [15:0] c_ifg_last  = 16'(2 * IFG_BYTES - 1);
  localparam logic [11:0] c_min_frame = 12'(MIN_FRAME);
  localparam logic [31:0] c_poly      = 32'hEDB88320;
  // Zero-length preamble or gap simply skips that state.
  localparam state_t      c_first     = (PREAMBLE_BYTES == 0) ? S_SFD : S_PRE;
  localparam state_t      c_gap       = (IFG_BYTES == 0) ? S_IDLE : S_IFG;

  state_t      r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n;          // cycle counter for PRE/SFD/FCS/IFG
  logic        r_phase, w_phase_n;      // nibble phase inside a byte
  logic [7:0]  r_byte, w_byte_n;        // byte currently on the wire
  logic        r_last, w_last_n;
  logic [10:0] r_bcnt, w_bcnt_n;        // bytes completed, saturating
  logic [31:0] r_crc, w_crc_n;
  logic        r_en, r_done, r_underrun;
  logic [3:0]  r_txd;
  logic        w_en_n, w_done_n, w_underrun_n;
  logic [3:0]  w_txd_n;
  logic [10:0] w_bcnt_inc;
  logic        w_short;
  logic [31:0] w_fcs;

  // Reflected CRC-32 advanced by one nibble, LSB first.
  function automatic logic [31:0] f_crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ c_poly) : (c >> 1);
    end
    return c;
  endfunction

  assign w_bcnt_inc = (r_bcnt == 11'h7FF) ? r_bcnt : r_bcnt + 11'd1;
  assign w_short    = ({1'b0, w_bcnt_inc} < c_min_frame);
  assign w_fcs      = ~w_crc_n;

  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DATA) && r_phase && !r_last);
  assign busy       = (r_state != S_IDLE);
  assign eth_tx_en  = r_en;
  assign eth_txd    = r_txd;
  assign frame_done = r_done;
  assign underrun   = r_underrun;

  // State, counters, CRC and the registered PHY outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_byte     <= '0;
      r_last     <= 1'b0;
      r_bcnt     <= '0;
      r_crc      <= '1;
      r_en       <= 1'b0;
      r_txd      <= '0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_phase    <= w_phase_n;
      r_byte     <= w_byte_n;
      r_last     <= w_last_n;
      r_bcnt     <= w_bcnt_n;
      r_crc      <= w_crc_n;
      r_en       <= w_en_n;
      r_txd      <= w_txd_n;
      r_done     <= w_done_n;
      r_underrun <= w_underrun_n;
    end
  end

  // Next-state logic; the CRC absorbs the nibble currently on the wire.
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_phase_n    = r_phase;
    w_byte_n     = r_byte;
    w_last_n     = r_last;
    w_bcnt_n     = r_bcnt;
    w_crc_n      = r_crc;
    w_underrun_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_byte_n  = in_data;
          w_last_n  = in_last;
          w_bcnt_n  = '0;
          w_crc_n   = '1;
          w_cnt_n   = '0;
          w_phase_n = 1'b0;
          w_state_n = c_first;
        end
      end
      S_PRE: begin
        if (r_cnt == c_pre_last) begin
          w_cnt_n   = '0;
          w_state_n = S_SFD;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      S_SFD: begin
        if (r_cnt == 16'd1) begin
          w_cnt_n   = '0;
          w_phase_n = 1'b0;
          w_state_n = S_DATA;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      S_DATA: begin
        w_crc_n = f_crc_nibble(r_crc, r_phase ? r_byte[7:4] : r_byte[3:0]);
        if (!r_phase) begin
          w_phase_n = 1'b1;
        end else begin
          w_phase_n = 1'b0;
          w_bcnt_n  = w_bcnt_inc;
          if (r_last) begin
            w_cnt_n   = '0;
            w_state_n = w_short ? S_PAD : S_FCS;
          end else if (in_valid) begin
            w_byte_n = in_data;
            w_last_n = in_last;
          end else begin
            // Source starved mid-frame: abandon without FCS.
            w_cnt_n      = '0;
            w_underrun_n = 1'b1;
            w_state_n    = c_gap;
          end
        end
      end
      S_PAD: begin
        w_crc_n = f_crc_nibble(r_crc, 4'h0);
        if (!r_phase) begin
          w_phase_n = 1'b1;
        end else begin
          w_phase_n = 1'b0;
          w_bcnt_n  = w_bcnt_inc;
          if (!w_short) begin
            w_cnt_n   = '0;
            w_state_n = S_FCS;
          end
        end
      end
      S_FCS: begin
        if (r_cnt == 16'd7) begin
          w_cnt_n   = '0;
          w_state_n = c_gap;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      S_IFG: begin
        if (r_cnt == c_ifg_last) begin
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins line up with it.
  always_comb begin
    w_en_n   = 1'b0;
    w_txd_n  = 4'h0;
    w_done_n = 1'b0;
    case (w_state_n)
      S_PRE: begin
        w_en_n  = 1'b1;
        w_txd_n = 4'h5;
      end
      S_SFD: begin
        w_en_n  = 1'b1;
        w_txd_n = (w_cnt_n == 16'd1) ? 4'hD : 4'h5;
      end
      S_DATA: begin
        w_en_n  = 1'b1;
        w_txd_n = w_phase_n ? w_byte_n[7:4] : w_byte_n[3:0];
      end
      S_PAD: begin
        w_en_n  = 1'b1;
        w_txd_n = 4'h0;
      end
      S_FCS: begin
        w_en_n   = 1'b1;
        w_txd_n  = w_fcs[{w_cnt_n[2:0], 2'b00} +: 4];
        w_done_n = (w_cnt_n == 16'd7);
      end
      default: begin
        w_en_n  = 1'b0;
        w_txd_n = 4'h0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mii_tx_framer
//  Description : Self-checking bench for mii_tx_framer with a byte-level
//                frame model (preamble, pad, CRC-32) and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mii_tx_framer;

  localparam int PRE_NIB = 14;
  localparam int LIM     = 5000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0, in_last = 1'b0;
  logic       in_ready, eth_tx_en, busy, frame_done, underrun;
  logic [3:0] eth_txd;

  logic [7:0] z_data = 8'h00;
  logic       z_valid = 1'b0, z_last = 1'b0;
  logic       z_ready, z_en, z_busy, z_done, z_underrun;
  logic [3:0] z_txd;

  int n_cmp = 0;
  int n_fail = 0;

  logic [3:0] cap[$];
  logic [3:0] cap0[$];
  logic [3:0] exp_q[$];
  int   cyc = 0, done_cnt = 0, ur_cnt = 0, en_fall_cyc = 0, acc_gap = -1;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  mii_tx_framer u_dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .eth_tx_en(eth_tx_en), .eth_txd(eth_txd), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  mii_tx_framer #(.MIN_FRAME(0)) u_nopad (
    .clk(clk), .rstn(rstn), .in_data(z_data), .in_valid(z_valid), .in_last(z_last),
    .in_ready(z_ready), .eth_tx_en(z_en), .eth_txd(z_txd), .busy(z_busy),
    .frame_done(z_done), .underrun(z_underrun)
  );

  // Wire monitor: nibble capture, pulse counts and gap timing.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (eth_tx_en) cap.push_back(eth_txd);
    if (z_en) cap0.push_back(z_txd);
    if (frame_done) done_cnt <= done_cnt + 1;
    if (underrun) ur_cnt <= ur_cnt + 1;
    if (prev_en && !eth_tx_en) en_fall_cyc <= cyc;
    if (!busy && in_valid && in_ready) acc_gap <= cyc - en_fall_cyc;
    prev_en <= eth_tx_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Expected wire nibbles for one frame, appended to exp_q.
  task automatic add_exp(input logic [7:0] pl[$], input int minf);
    logic [7:0]  fr[$];
    logic [31:0] c;
    fr = pl;
    while (fr.size() < minf) fr.push_back(8'h00);
    repeat (PRE_NIB + 1) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    c = 32'hFFFFFFFF;
    foreach (fr[i]) begin
      exp_q.push_back(fr[i][3:0]);
      exp_q.push_back(fr[i][7:4]);
      c = crc_byte(c, fr[i]);
    end
    c = ~c;
    for (int k = 0; k < 8; k++) exp_q.push_back(c[4*k +: 4]);
  endtask

  task automatic push(input int sel, input logic [7:0] d, input logic l);
    int g = 0;
    if (sel == 0) begin in_data = d; in_last = l; in_valid = 1'b1; end
    else begin z_data = d; z_last = l; z_valid = 1'b1; end
    while (((sel == 0) ? !in_ready : !z_ready) && g < LIM) begin tick(); g++; end
    chk("push_accept", 32'(g < LIM), 1);
    tick();
  endtask

  task automatic send(input int sel, input logic [7:0] pl[$], input bit hold);
    foreach (pl[i]) push(sel, pl[i], (i == pl.size() - 1));
    if (!hold) begin
      if (sel == 0) in_valid = 1'b0; else z_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int sel, input string tag);
    int g = 0;
    while (!((sel == 0) ? frame_done : z_done) && g < LIM) begin tick(); g++; end
    chk({tag, "_done_seen"}, 32'(g < LIM), 1);
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while ((busy || z_busy) && g < LIM) begin tick(); g++; end
    chk({tag, "_idle"}, 32'(g < LIM), 1);
  endtask

  task automatic cmp_stream(input string tag, input int sel);
    logic [3:0] got[$];
    int bad = 0;
    if (sel == 0) got = cap; else got = cap0;
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    chk({tag, "_bad_nibbles"}, bad, 0);
  endtask

  initial begin
    logic [7:0]  pl[$];
    logic [7:0]  pb[$];
    logic [31:0] f;
    int g, n, d0, u0, len;

    // Reset state
    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_en", 32'(eth_tx_en), 0);
    chk("rst_txd", 32'(eth_txd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ready", 32'(in_ready), 1);
    rstn = 1'b1;
    tick();

    // 60-byte frame 0x00..0x3B
    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'(i));
    exp_q.delete(); add_exp(pl, 60);
    cap.delete(); d0 = done_cnt;
    send(0, pl, 0);
    wait_done(0, "t1");
    chk("t1_en_at_done", 32'(eth_tx_en), 1);
    chk("t1_len_at_done", cap.size(), 144);
    cmp_stream("t1", 0);
    tick();
    chk("t1_en_after_done", 32'(eth_tx_en), 0);
    n = 0;
    while (!in_ready && n < 100) begin n++; tick(); end
    chk("t1_ready_low_cycles", n, 24);
    chk("t1_done_count", done_cnt - d0, 1);

    // No-padding instance, "123456789"
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    exp_q.delete(); add_exp(pl, 0);
    cap0.delete();
    send(1, pl, 0);
    wait_done(1, "t2");
    cmp_stream("t2", 1);
    f = '0;
    for (int k = 0; k < 8; k++) f[4*k +: 4] = cap0[cap0.size() - 8 + k];
    chk("t2_fcs", f, 32'hCBF43926);
    wait_idle("t2");

    // 9-byte frame padded to 60
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'($urandom));
    exp_q.delete(); add_exp(pl, 60);
    cap.delete();
    send(0, pl, 0);
    wait_done(0, "t3");
    cmp_stream("t3", 0);
    n = 0;
    for (int i = PRE_NIB + 2 + 18; i < PRE_NIB + 2 + 120 && i < cap.size(); i++)
      if (cap[i] !== 4'h0) n++;
    chk("t3_pad_nonzero", n, 0);
    f = 32'hFFFFFFFF;
    for (int i = PRE_NIB + 2; i + 1 < cap.size(); i += 2) f = crc_byte(f, {cap[i+1], cap[i]});
    chk("t3_residue", f, 32'hDEBB20E3);
    wait_idle("t3");

    // Underrun after 20 bytes
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
    exp_q.delete(); add_exp(pl, 0);
    repeat (8) void'(exp_q.pop_back());
    cap.delete(); d0 = done_cnt; u0 = ur_cnt;
    foreach (pl[i]) push(0, pl[i], 1'b0);
    in_valid = 1'b0;
    g = 0;
    while (!underrun && g < 50) begin tick(); g++; end
    chk("t4_underrun_seen", 32'(g < 50), 1);
    chk("t4_en_at_underrun", 32'(eth_tx_en), 0);
    n = 0;
    while (!in_ready && n < 100) begin n++; tick(); end
    chk("t4_ifg_cycles", n, 24);
    chk("t4_underrun_count", ur_cnt - u0, 1);
    chk("t4_no_done", done_cnt - d0, 0);
    cmp_stream("t4", 0);

    // Back-to-back frames, valid held high
    pl.delete(); pb.delete();
    len = $urandom_range(60, 70);
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    len = $urandom_range(1, 70);
    for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
    exp_q.delete(); add_exp(pl, 60); add_exp(pb, 60);
    cap.delete(); d0 = done_cnt;
    send(0, pl, 1);
    send(0, pb, 0);
    wait_idle("t5");
    chk("t5_gap_cycles", acc_gap, 24);
    chk("t5_done_count", done_cnt - d0, 2);
    cmp_stream("t5", 0);

    // Random frames with random idle lead-in
    for (int r = 0; r < 4; r++) begin
      pl.delete();
      len = $urandom_range(1, 100);
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      repeat ($urandom_range(0, 6)) tick();
      exp_q.delete(); add_exp(pl, 60);
      cap.delete();
      send(0, pl, 0);
      wait_done(0, "t6");
      wait_idle("t6");
      cmp_stream("t6", 0);
    end

    // Reset asserted during FCS
    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'($urandom));
    cap.delete();
    send(0, pl, 0);
    g = 0;
    while (cap.size() < 140 && g < LIM) begin tick(); g++; end
    chk("t7_reached_fcs", 32'(g < LIM), 1);
    rstn = 1'b0;
    #1;
    chk("t7_en_on_reset", 32'(eth_tx_en), 0);
    chk("t7_busy_on_reset", 32'(busy), 0);
    repeat (2) tick();
    rstn = 1'b1;
    chk("t7_ready_after_reset", 32'(in_ready), 1);
    pl.delete();
    len = $urandom_range(1, 30);
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    exp_q.delete(); add_exp(pl, 60);
    cap.delete();
    send(0, pl, 0);
    wait_done(0, "t7");
    wait_idle("t7");
    cmp_stream("t7", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
